// File: rtl/regdump.sv
// -----------------------------------------------------------------------------
// regdump
//
// Streams a contiguous range of register-file entries (FIRST_REG..LAST_REG) out
// over a valid/ready interface, one register per request.
//
// The design fetches one register, then presents it until the consumer accepts
// it. That gives at most one word every two cycles. A dump is started by
// sampling start in IDLE. Requests that arrive while a dump is in progress are
// dropped, not queued.
//
// Ports
//   clk         in   1   single clock, all state changes on its rising edge
//   reset       in   1   asynchronous, active-high reset
//   start       in   1   request a dump (honoured only in IDLE)
//   ra          out  5   register-file read address (always the pointer)
//   rd          in  64   register-file read data, combinational from ra
//   dout_valid  out  1   dout_data/dout_idx hold a register value
//   dout_ready  in   1   consumer accepts the current word
//   dout_data   out 64   captured register value
//   dout_idx    out  5   register index belonging to dout_data
//   busy        out  1   high whenever the FSM is not in IDLE
//   done        out  1   one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module regdump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  ra,
    input  logic [63:0] rd,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [63:0] dout_data,
    output logic [4:0]  dout_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_P = 5'(FIRST_REG);
    localparam logic [4:0] LAST_P  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  ptr_q,   ptr_d;
    logic [63:0] data_q,  data_d;
    logic [4:0]  idx_q,   idx_d;
    logic        valid_q, valid_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    // Status outputs are registered. Each flag is set on the transition into
    // the state it describes, so it exactly tracks state_q without any
    // decode logic on the output path.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = FIRST_P;
                    state_d = FETCH;
                    busy_d  = 1'b1;
                end
            end

            // rd is only ever captured here. Later changes in the register
            // file cannot disturb a word that is already on offer.
            FETCH: begin
                data_d  = rd;
                idx_d   = ptr_q;
                state_d = SEND;
                valid_d = 1'b1;
            end

            SEND: begin
                if (dout_ready) begin
                    valid_d = 1'b0;
                    if (ptr_q == LAST_P) begin
                        // The pointer stays parked on the last index.
                        // It never wraps to 0 inside a dump.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d   = ptr_q + 5'd1;
                        state_d = FETCH;
                    end
                end
            end

            // A start seen in this cycle is deliberately dropped. A new dump
            // needs start to be present while the FSM is back in IDLE.
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // The captured data is also cleared on reset. A dump aborted by reset
    // then leaves nothing stale on dout_data/dout_idx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 5'd0;
            data_q  <= 64'd0;
            idx_q   <= 5'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ra         = ptr_q;
    assign dout_valid = valid_q;
    assign dout_data  = data_q;
    assign dout_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_regdump.sv
module tb_regdump;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  ra;
    logic [63:0] rd;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [63:0] dout_data;
    logic [4:0]  dout_idx;
    logic        busy;
    logic        done;

    // Second instance configured for a single-register dump.
    logic        start1 = 1'b0;
    logic [4:0]  ra1;
    logic [63:0] rd1;
    logic        dout_valid1;
    logic        dout_ready1 = 1'b1;
    logic [63:0] dout_data1;
    logic [4:0]  dout_idx1;
    logic        busy1;
    logic        done1;

    logic [63:0] regs [32];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rd  = regs[ra];
    assign rd1 = regs[ra1];

    regdump dut (
        .clk(clk), .reset(reset), .start(start), .ra(ra), .rd(rd),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_idx(dout_idx), .busy(busy), .done(done)
    );

    regdump #(.FIRST_REG(7), .LAST_REG(7)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ra(ra1), .rd(rd1),
        .dout_valid(dout_valid1), .dout_ready(dout_ready1), .dout_data(dout_data1),
        .dout_idx(dout_idx1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic [4:0]  exp_idx;
        logic [63:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
        logic [4:0]  exp_ra;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        dout_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Holds ready high and follows one dump to completion.
    // The caller must already have put the FSM in FETCH for register `first`.
    task automatic collect(input string tag, input int first, input int last, input int budget);
        int nxt = first;
        int words = 0;
        int last_cyc = -1;
        bit finished = 1'b0;
        dout_ready = 1'b1;
        for (int c = 0; c < budget && !finished; c++) begin
            step();
            if (dout_valid) begin
                check({tag, "_idx"}, 64'(dout_idx), 64'(nxt));
                check({tag, "_data"}, dout_data, 64'h1000 + 64'(nxt));
                if (last_cyc >= 0) check({tag, "_gap"}, 64'(c - last_cyc), 64'd2);
                last_cyc = c;
                nxt++;
                words++;
            end
            if (done) finished = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(finished), 64'd1);
        check({tag, "_words"}, 64'(words), 64'(last - first + 1));
        step();
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_done_once"}, 64'(done), 64'd0);
    endtask

    // Advance with ready high until word `idx` is being offered, then hold it there.
    task automatic run_to_idx(input string tag, input int idx);
        bit hit = 1'b0;
        dout_ready = 1'b1;
        for (int c = 0; c < 100 && !hit; c++) begin
            step();
            if (dout_valid && dout_idx == 5'(idx)) begin
                hit = 1'b1;
                dout_ready = 1'b0;
            end
        end
        check({tag, "_reached"}, 64'(hit), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);

        //            start ready valid idx  data        busy done ra
        tbl[0] = '{1'b0, 1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 1'b0, 5'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 5'd0, 64'h0,     1'b1, 1'b0, 5'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 5'd0, 64'h1000,  1'b1, 1'b0, 5'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 5'd0, 64'h1000,  1'b1, 1'b0, 5'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 5'd0, 64'h1000,  1'b1, 1'b0, 5'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 5'd1, 64'h1001,  1'b1, 1'b0, 5'd1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 5'd1, 64'h1001,  1'b1, 1'b0, 5'd2};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 5'd2, 64'h1002,  1'b1, 1'b0, 5'd2};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 5'd2, 64'h1002,  1'b1, 1'b0, 5'd3};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 5'd3, 64'h1003,  1'b1, 1'b0, 5'd3};

        // Reset state, observed while reset is held.
        #1;
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ra", 64'(ra), 64'd0);
        check("rst_data", dout_data, 64'd0);
        check("rst_idx", 64'(dout_idx), 64'd0);
        do_reset();

        // Table: start latency, ignored start while busy, stalls, handshakes.
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start;
            dout_ready = tbl[i].ready;
            step();
            check($sformatf("vec%0d_valid", i), 64'(dout_valid), 64'(tbl[i].exp_valid));
            check($sformatf("vec%0d_idx", i), 64'(dout_idx), 64'(tbl[i].exp_idx));
            check($sformatf("vec%0d_data", i), dout_data, tbl[i].exp_data);
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].exp_busy));
            check($sformatf("vec%0d_done", i), 64'(done), 64'(tbl[i].exp_done));
            check($sformatf("vec%0d_ra", i), 64'(ra), 64'(tbl[i].exp_ra));
        end
        start = 1'b0;

        // Consumer stalls for 5 cycles while word 3 is offered.
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 64'(dout_valid), 64'd1);
            check("stall_data", dout_data, 64'h1003);
            check("stall_idx", 64'(dout_idx), 64'd3);
        end
        dout_ready = 1'b1;
        step();
        check("stall_release_valid", 64'(dout_valid), 64'd0);
        check("stall_release_ra", 64'(ra), 64'd4);
        collect("stall_rest", 4, 30, 100);

        // Full dump with ready held high.
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        check("full_busy_fetch", 64'(busy), 64'd1);
        collect("full", 0, 30, 100);

        // Start held high: the second dump begins only after IDLE.
        do_reset();
        start = 1'b1;
        step();
        collect("held", 0, 30, 100);
        step();
        check("held_restart_busy", 64'(busy), 64'd1);
        check("held_restart_ra", 64'(ra), 64'd0);
        check("held_restart_valid", 64'(dout_valid), 64'd0);
        step();
        check("held_restart_idx", 64'(dout_idx), 64'd0);
        check("held_restart_vld", 64'(dout_valid), 64'd1);
        start = 1'b0;

        // Reset while word 12 is being offered.
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_idx("abort", 12);
        check("abort_pre_data", dout_data, 64'h100C);
        #2;
        reset = 1'b1;
        #1;
        check("abort_valid", 64'(dout_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ra", 64'(ra), 64'd0);
        check("abort_data", dout_data, 64'd0);
        start = 1'b1;
        step();
        check("abort_start_ignored", 64'(busy), 64'd0);
        start = 1'b0;
        reset = 1'b0;
        step();
        check("abort_idle_valid", 64'(dout_valid), 64'd0);
        check("abort_idle_busy", 64'(busy), 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("abort_restart_ra", 64'(ra), 64'd0);
        collect("abort_restart", 0, 30, 100);

        // Register changes after capture must not reach dout_data.
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_idx("rdchg", 5);
        regs[5] = 64'hDEAD_BEEF_0000_0005;
        step();
        check("rdchg_data0", dout_data, 64'h1005);
        step();
        check("rdchg_data1", dout_data, 64'h1005);
        check("rdchg_idx", 64'(dout_idx), 64'd5);
        regs[5] = 64'h1005;
        dout_ready = 1'b1;
        step();
        step();
        check("rdchg_next_idx", 64'(dout_idx), 64'd6);
        check("rdchg_next_data", dout_data, 64'h1006);

        // Single-register dump on the FIRST_REG=LAST_REG=7 instance.
        do_reset();
        dout_ready1 = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("one_fetch_busy", 64'(busy1), 64'd1);
        check("one_fetch_ra", 64'(ra1), 64'd7);
        check("one_fetch_valid", 64'(dout_valid1), 64'd0);
        step();
        check("one_send_valid", 64'(dout_valid1), 64'd1);
        check("one_send_idx", 64'(dout_idx1), 64'd7);
        check("one_send_data", dout_data1, 64'h1007);
        step();
        check("one_done", 64'(done1), 64'd1);
        check("one_done_valid", 64'(dout_valid1), 64'd0);
        check("one_done_ra", 64'(ra1), 64'd7);
        check("one_done_busy", 64'(busy1), 64'd1);
        step();
        check("one_idle_done", 64'(done1), 64'd0);
        check("one_idle_busy", 64'(busy1), 64'd0);
        check("one_idle_valid", 64'(dout_valid1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regdump.md
REGDUMP -- requirements
Module: regdump

Interface
REQ-001 Parameter: FIRST_REG, default 0, index of first register streamed.
REQ-002 Parameter: LAST_REG, default 30, index of last register streamed; X31 (XZR) excluded by default.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: start  in  1  request a dump; sampled on posedge clk.
REQ-006 Port: ra  out  5  register-file read address, driven from internal pointer.
REQ-007 Port: rd  in  64  register-file read data; combinational response to ra, same cycle.
REQ-008 Port: dout_valid  out  1  dout_data/dout_idx hold a valid register value.
REQ-009 Port: dout_ready  in  1  consumer accepts the current word.
REQ-010 Port: dout_data  out  64  captured register value.
REQ-011 Port: dout_idx  out  5  register index of dout_data.
REQ-012 Port: busy  out  1  high in every state other than IDLE.
REQ-013 Port: done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-014 Four states: IDLE, FETCH, SEND, DONE; 5-bit pointer ptr; ra SHALL equal ptr at all times.
REQ-015 IDLE: start=1 -> ptr<=FIRST_REG, next state FETCH; start=0 -> stay IDLE.
REQ-016 FETCH (one cycle): dout_data<=rd, dout_idx<=ptr, next state SEND.
REQ-017 SEND: dout_valid=1; dout_data and dout_idx held stable until dout_valid&&dout_ready.
REQ-018 SEND with dout_ready=0: stay SEND, no output or ptr change.
REQ-019 SEND with dout_ready=1 and ptr!=LAST_REG: ptr<=ptr+1, next state FETCH.
REQ-020 SEND with dout_ready=1 and ptr==LAST_REG: next state DONE; ptr unchanged.
REQ-021 DONE (one cycle): done=1, busy=1, next state IDLE.
REQ-022 dout_valid SHALL be 1 only in SEND; done SHALL be 1 only in DONE.
REQ-023 Latency: start sampled at edge N -> FETCH during cycle N..N+1 -> dout_valid=1 after edge N+1.
REQ-024 Throughput: at most one word per 2 cycles (FETCH+SEND per register).
REQ-025 start while busy (FETCH/SEND/DONE) SHALL be ignored, not queued.
REQ-026 start=1 in the DONE cycle SHALL be ignored; a new dump requires start in IDLE.
REQ-027 Word count per dump = LAST_REG-FIRST_REG+1; FIRST_REG==LAST_REG yields exactly one word.
REQ-028 ptr SHALL never exceed LAST_REG; no wrap-around to 0 within a dump.
REQ-029 rd is sampled only in FETCH; changes to rd in SEND SHALL NOT alter dout_data.

Reset
REQ-030 reset=1 SHALL asynchronously force state=IDLE, ptr=0, dout_data=0, dout_idx=0.
REQ-031 While reset=1: dout_valid=0, busy=0, done=0, ra=0; start ignored.
REQ-032 Reset mid-dump SHALL abort it; no further words; first clock edge after deassertion sees IDLE.

Verification
REQ-033 Regfile model X_i = 0x1000+i, start pulse, dout_ready=1 -> 31 words, idx 0..30, data 0x1000..0x101E, one per 2 cycles, done pulse once, busy falls after.
REQ-034 dout_ready low 5 cycles while idx=3 valid -> dout_data=0x1003 and dout_idx=3 stable all 5 cycles, idx 4 follows after ready.
REQ-035 FIRST_REG=LAST_REG=7 -> exactly one word idx 7, data 0x1007, then done.
REQ-036 start held high throughout dump -> second dump starts only from IDLE, no word duplicated or skipped within a dump.
REQ-037 Assert reset while idx=12 in SEND -> dout_valid and busy drop immediately, ra=0; after release, new start restarts at idx 0.
REQ-038 Modify X5 in the model while idx=5 in SEND -> dout_data remains the value captured in FETCH.
